// File: rtl/eth_rx_pkg.sv
// Shared types for the receive-stream drainer: FSM encoding, output FIFO
// entry layout and the tkeep helper.
package eth_rx_pkg;

  localparam int max_dw_lp   = 64;
  localparam int max_keep_lp = max_dw_lp / 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_READ      = 3'd1,
    ST_DRAIN     = 3'd2,
    ST_CLEAR     = 3'd3,
    ST_WAIT_NRDY = 3'd4
  } drain_state_e;

  // Sized for the widest stream; narrower builds use the low bits.
  typedef struct packed {
    logic [max_dw_lp-1:0]   data;
    logic [max_keep_lp-1:0] keep;
    logic                   last;
  } fifo_entry_t;

  // Low 'rem' bytes enabled; rem==0 means a full word of nbytes.
  function automatic logic [max_keep_lp-1:0] keep_for_bytes(input logic [2:0] rem,
                                                             input int nbytes);
    logic [max_keep_lp-1:0] m;
    m = '0;
    for (int i = 0; i < max_keep_lp; i++)
      if (i < nbytes && (rem == 3'd0 || i < int'(rem))) m[i] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/eth_rx_skid_fifo.sv
// Two-entry valid/ready FIFO. The head entry drives the outputs directly
// from storage, so downstream ready never reaches the upstream side
// combinationally. The writer guarantees space via its own credit count.
module eth_rx_skid_fifo #(
  parameter int width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  input  logic               ready_i,
  output logic [width_p-1:0] data_o,
  output logic [1:0]         count_o
);

  logic [width_p-1:0] mem_r [2];
  logic               wr_ptr_r, rd_ptr_r;
  logic [1:0]         cnt_r;
  logic               pop;

  assign v_o     = (cnt_r != 2'd0);
  assign data_o  = mem_r[rd_ptr_r];
  assign count_o = cnt_r;
  assign pop     = v_o & ready_i;

  // Storage, pointers and occupancy; push+pop together leaves count alone.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < 2; i++) mem_r[i] <= '0;
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      cnt_r    <= 2'd0;
    end else begin
      if (v_i) begin
        mem_r[wr_ptr_r] <= data_i;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (pop) rd_ptr_r <= ~rd_ptr_r;
      case ({v_i, pop})
        2'b10:   cnt_r <= cnt_r + 2'd1;
        2'b01:   cnt_r <= cnt_r - 2'd1;
        default: cnt_r <= cnt_r;
      endcase
    end
  end

endmodule

// File: rtl/eth_rx_stream_drainer.sv
// Drains a complete frame from the receive buffer onto an AXI-stream
// master, then releases the buffer with a one-cycle clear pulse.
module eth_rx_stream_drainer
  import eth_rx_pkg::*;
#(
  parameter  int buf_size_p    = 2048,
  parameter  int data_width_p  = 64,
  localparam int addr_width_lp = $clog2(buf_size_p),
  localparam int bytes_lp      = data_width_p / 8
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     rx_ready_i,
  input  logic [15:0]              rx_packet_size_i,
  output logic                     clear_buffer_o,
  output logic                     buffer_read_v_o,
  output logic [addr_width_lp-1:0] buffer_read_addr_o,
  output logic [1:0]               buffer_read_op_size_o,
  input  logic [data_width_p-1:0]  buffer_read_data_i,
  output logic [data_width_p-1:0]  m_tdata_o,
  output logic [bytes_lp-1:0]      m_tkeep_o,
  output logic                     m_tlast_o,
  output logic                     m_tvalid_o,
  input  logic                     m_tready_i,
  output logic [15:0]              packet_count_o,
  output logic [15:0]              drop_count_o
);

  localparam int lg_bytes_lp = $clog2(bytes_lp);

  drain_state_e             state_r, state_n;
  logic [2:0]               rem_r;         // latched size mod bytes_lp
  logic [15:0]              words_r, rd_idx_r, push_idx_r;
  logic [addr_width_lp-1:0] rd_addr_r;
  logic                     streamed_r;
  logic                     inflight_r;    // read issued last cycle, data arriving now
  logic [15:0]              pkt_cnt_r, drop_cnt_r;

  logic [15:0] words_n;
  logic        size_bad, rd_issue, last_word, drain_done;
  logic [1:0]  fifo_cnt;
  fifo_entry_t push_ent, head_ent;

  assign words_n  = 16'(({1'b0, rx_packet_size_i} + 17'(bytes_lp - 1)) >> lg_bytes_lp);
  assign size_bad = (rx_packet_size_i == 16'd0) || (rx_packet_size_i > 16'(buf_size_p));

  // Credit: FIFO entries plus the read in flight never exceed the FIFO depth.
  assign rd_issue = (state_r == ST_READ) && ((fifo_cnt + {1'b0, inflight_r}) < 2'd2);

  // Done when the last queued beat leaves this cycle and nothing is in flight,
  // so the clear pulse lands the cycle right after the final handshake.
  assign drain_done = !inflight_r &&
                      ((fifo_cnt == 2'd0) || (fifo_cnt == 2'd1 && m_tvalid_o && m_tready_i));

  assign buffer_read_v_o       = rd_issue;
  assign buffer_read_addr_o    = rd_addr_r;
  assign buffer_read_op_size_o = 2'(lg_bytes_lp);
  assign clear_buffer_o        = (state_r == ST_CLEAR);
  assign packet_count_o        = pkt_cnt_r;
  assign drop_count_o          = drop_cnt_r;

  // Tag each returning word with its keep mask and last flag.
  always_comb begin
    last_word                          = (push_idx_r == words_r - 16'd1);
    push_ent                           = '0;
    push_ent.data[data_width_p-1:0]    = buffer_read_data_i;
    push_ent.keep                      = keep_for_bytes(last_word ? rem_r : 3'd0, bytes_lp);
    push_ent.last                      = last_word;
  end

  eth_rx_skid_fifo #(.width_p($bits(fifo_entry_t))) u_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .v_i       (inflight_r),
    .data_i    (push_ent),
    .v_o       (m_tvalid_o),
    .ready_i   (m_tready_i),
    .data_o    (head_ent),
    .count_o   (fifo_cnt)
  );

  assign m_tdata_o = head_ent.data[data_width_p-1:0];
  assign m_tkeep_o = head_ent.keep[bytes_lp-1:0];
  assign m_tlast_o = head_ent.last;

  // Next-state logic.
  always_comb begin
    state_n = state_r;
    case (state_r)
      ST_IDLE:      if (rx_ready_i) state_n = size_bad ? ST_CLEAR : ST_READ;
      ST_READ:      if (rd_issue && rd_idx_r == words_r - 16'd1) state_n = ST_DRAIN;
      ST_DRAIN:     if (drain_done) state_n = ST_CLEAR;
      ST_CLEAR:     state_n = ST_WAIT_NRDY;
      ST_WAIT_NRDY: if (!rx_ready_i) state_n = ST_IDLE;
      default:      state_n = ST_IDLE;
    endcase
  end

  // State, frame bookkeeping and counters.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r    <= ST_IDLE;
      rem_r      <= 3'd0;
      words_r    <= 16'd0;
      rd_idx_r   <= 16'd0;
      push_idx_r <= 16'd0;
      rd_addr_r  <= '0;
      streamed_r <= 1'b0;
      inflight_r <= 1'b0;
      pkt_cnt_r  <= 16'd0;
      drop_cnt_r <= 16'd0;
    end else begin
      state_r    <= state_n;
      inflight_r <= rd_issue;
      if (state_r == ST_IDLE && rx_ready_i) begin
        rem_r      <= 3'(rx_packet_size_i[lg_bytes_lp-1:0]);
        words_r    <= words_n;
        rd_idx_r   <= 16'd0;
        push_idx_r <= 16'd0;
        rd_addr_r  <= '0;
        streamed_r <= !size_bad;
        if (size_bad) drop_cnt_r <= drop_cnt_r + 16'd1;
      end
      if (rd_issue) begin
        rd_idx_r  <= rd_idx_r + 16'd1;
        rd_addr_r <= rd_addr_r + addr_width_lp'(bytes_lp);
      end
      if (inflight_r) push_idx_r <= push_idx_r + 16'd1;
      if (state_r == ST_CLEAR && streamed_r) pkt_cnt_r <= pkt_cnt_r + 16'd1;
    end
  end

endmodule

// File: tb/tb_eth_rx_stream_drainer.sv
// Randomised bench: a byte-array buffer model answers reads one cycle late,
// frames are turned into expected beats from the byte array, and a monitor
// pops and compares every accepted beat.
module tb_eth_rx_stream_drainer;

  localparam int BUF = 2048;
  localparam int B   = 8;

  logic        clk = 1'b0;
  logic        reset_n_i = 1'b0;
  logic        rx_ready_i = 1'b0;
  logic [15:0] rx_packet_size_i = 16'd0;
  logic        clear_buffer_o, buffer_read_v_o;
  logic [10:0] buffer_read_addr_o;
  logic [1:0]  buffer_read_op_size_o;
  logic [63:0] buffer_read_data_i = 64'd0;
  logic [63:0] m_tdata_o;
  logic [7:0]  m_tkeep_o;
  logic        m_tlast_o, m_tvalid_o;
  logic        m_tready_i = 1'b1;
  logic [15:0] packet_count_o, drop_count_o;

  eth_rx_stream_drainer #(.buf_size_p(BUF), .data_width_p(64)) dut (
    .clk_i                 (clk),
    .reset_n_i             (reset_n_i),
    .rx_ready_i            (rx_ready_i),
    .rx_packet_size_i      (rx_packet_size_i),
    .clear_buffer_o        (clear_buffer_o),
    .buffer_read_v_o       (buffer_read_v_o),
    .buffer_read_addr_o    (buffer_read_addr_o),
    .buffer_read_op_size_o (buffer_read_op_size_o),
    .buffer_read_data_i    (buffer_read_data_i),
    .m_tdata_o             (m_tdata_o),
    .m_tkeep_o             (m_tkeep_o),
    .m_tlast_o             (m_tlast_o),
    .m_tvalid_o            (m_tvalid_o),
    .m_tready_i            (m_tready_i),
    .packet_count_o        (packet_count_o),
    .drop_count_o          (drop_count_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } beat_t;

  logic [7:0] mem_b [BUF];
  beat_t      exp_q [$];
  int checks = 0, passes = 0;
  int cyc = 0, clear_seen = 0, last_cyc = -10, rd_cnt = 0, acc_cnt = 0;
  int tr_mode = 0, exp_pkt = 0, exp_drop = 0;
  bit pending_clear = 0;

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [63:0] word_at(input int addr);
    logic [63:0] w;
    for (int b = 0; b < B; b++) w[8*b +: 8] = mem_b[(addr + b) % BUF];
    return w;
  endfunction

  // Expected beats straight from the byte layout of the frame.
  task automatic push_frame(input int size);
    int words, rem;
    beat_t e;
    words = (size + B - 1) / B;
    rem   = size % B;
    for (int w = 0; w < words; w++) begin
      e.d = word_at(w * B);
      e.l = (w == words - 1);
      e.k = (e.l && rem != 0) ? 8'((1 << rem) - 1) : 8'hFF;
      exp_q.push_back(e);
    end
  endtask

  // Buffer model: fixed one-cycle read latency.
  initial forever begin
    @(posedge clk);
    if (buffer_read_v_o) buffer_read_data_i <= word_at(int'(buffer_read_addr_o));
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Ready pattern.
  initial forever begin
    @(posedge clk); #1;
    case (tr_mode)
      0:       m_tready_i = 1'b1;
      1:       m_tready_i = ~m_tready_i;
      default: m_tready_i = ($urandom_range(0, 9) < 7);
    endcase
  end

  // Monitor: scoreboard pop, hold-while-stalled, outstanding bound, clear timing.
  initial begin
    bit          prev_stall;
    logic [63:0] pd;
    logic [7:0]  pk;
    logic        pl;
    logic [63:0] m;
    beat_t       e;
    prev_stall = 0;
    forever begin
      @(negedge clk);
      if (!reset_n_i) begin
        prev_stall = 0;
        continue;
      end
      if (prev_stall)
        check(m_tvalid_o && m_tdata_o == pd && m_tkeep_o == pk && m_tlast_o == pl,
              "stall_hold", {m_tdata_o[54:0], m_tkeep_o, m_tlast_o}, {pd[54:0], pk, pl});
      if (buffer_read_v_o) begin
        check(rd_cnt + 1 - acc_cnt <= 2, "outstanding", 64'(rd_cnt + 1 - acc_cnt), 64'd2);
        rd_cnt++;
      end
      if (m_tvalid_o && m_tready_i) begin
        acc_cnt++;
        if (exp_q.size() == 0) check(0, "unexpected_beat", m_tdata_o, 64'd0);
        else begin
          e = exp_q.pop_front();
          m = '0;
          for (int b = 0; b < B; b++) if (e.k[b]) m[8*b +: 8] = 8'hFF;
          check((m_tdata_o & m) == (e.d & m), "beat_data", m_tdata_o & m, e.d & m);
          check(m_tkeep_o == e.k, "beat_keep", 64'(m_tkeep_o), 64'(e.k));
          check(m_tlast_o == e.l, "beat_last", 64'(m_tlast_o), 64'(e.l));
        end
        if (m_tlast_o) begin
          pending_clear = 1;
          last_cyc = cyc;
        end
      end
      if (clear_buffer_o) begin
        clear_seen++;
        if (pending_clear) check(cyc == last_cyc + 1, "clear_timing", 64'(cyc - last_cyc), 64'd1);
        pending_clear = 0;
      end
      prev_stall = m_tvalid_o && !m_tready_i;
      pd = m_tdata_o; pk = m_tkeep_o; pl = m_tlast_o;
    end
  end

  // rx_ready_i was driven just after an edge: first beat must appear 3 edges later.
  task automatic measure_latency();
    int n;
    n = 0;
    for (int i = 1; i <= 10; i++) begin
      @(posedge clk); #1;
      if (m_tvalid_o) begin n = i; break; end
    end
    check(n == 3, "first_beat_latency", 64'(n), 64'd3);
  endtask

  task automatic wait_clear(input int c0);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #1;
      if (clear_seen != c0) break;
    end
    check(clear_seen == c0 + 1, "clear_pulse", 64'(clear_seen - c0), 64'd1);
  endtask

  task automatic finish_frame();
    @(posedge clk); #1;
    rx_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check(exp_q.size() == 0, "all_beats_seen", 64'(exp_q.size()), 64'd0);
    check(packet_count_o == 16'(exp_pkt), "packet_count", 64'(packet_count_o), 64'(exp_pkt));
    check(drop_count_o == 16'(exp_drop), "drop_count", 64'(drop_count_o), 64'(exp_drop));
  endtask

  task automatic run_frame(input int size, input int mode, input bit stale_hold);
    bit bad;
    int c0;
    bad = (size == 0) || (size > BUF);
    for (int i = 0; i < BUF; i++) mem_b[i] = 8'($urandom);
    tr_mode = mode;
    if (bad) exp_drop++;
    else begin
      exp_pkt++;
      push_frame(size);
    end
    c0 = clear_seen;
    @(posedge clk); #1;
    rx_packet_size_i = 16'(size);
    rx_ready_i       = 1'b1;
    if (!bad) measure_latency();
    wait_clear(c0);
    if (stale_hold) begin
      rx_packet_size_i = 16'd24;
      repeat (5) @(posedge clk);
      #1;
      check(clear_seen == c0 + 1, "stale_no_reclear", 64'(clear_seen - c0), 64'd1);
      check(!m_tvalid_o && !buffer_read_v_o, "stale_no_restream",
            64'({m_tvalid_o, buffer_read_v_o}), 64'd0);
    end
    finish_frame();
  endtask

  initial begin
    int c0;
    #2_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    for (int i = 0; i < BUF; i++) mem_b[i] = 8'($urandom);
    #1;
    check(!m_tvalid_o && !buffer_read_v_o && !clear_buffer_o && m_tdata_o == 64'd0,
          "reset_outputs", {m_tdata_o[60:0], m_tvalid_o, buffer_read_v_o, clear_buffer_o}, 64'd0);
    check(packet_count_o == 16'd0 && drop_count_o == 16'd0, "reset_counters",
          64'({packet_count_o, drop_count_o}), 64'd0);
    check(buffer_read_op_size_o == 2'd3, "op_size", 64'(buffer_read_op_size_o), 64'd3);
    repeat (3) @(posedge clk);
    #1 reset_n_i = 1'b1;
    repeat (2) @(posedge clk);

    run_frame(64, 0, 0);
    run_frame(61, 0, 0);
    run_frame(64, 1, 0);
    run_frame(0, 0, 0);
    run_frame(2049, 0, 0);
    run_frame(40, 0, 1);
    run_frame(2048, 0, 0);
    run_frame(1, 2, 0);
    for (int i = 0; i < 8; i++) run_frame($urandom_range(1, BUF), 2, 0);

    // Mid-frame reset on a 128-byte frame, then full re-stream from byte 0.
    tr_mode = 0;
    for (int i = 0; i < BUF; i++) mem_b[i] = 8'($urandom);
    push_frame(128);
    c0 = acc_cnt;
    @(posedge clk); #1;
    rx_packet_size_i = 16'd128;
    rx_ready_i       = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (acc_cnt - c0 >= 3) break;
    end
    check(acc_cnt - c0 == 3, "beats_before_reset", 64'(acc_cnt - c0), 64'd3);
    reset_n_i = 1'b0;
    #1;
    check(!m_tvalid_o && !buffer_read_v_o && !clear_buffer_o && !m_tlast_o && m_tdata_o == 64'd0,
          "midframe_reset_outputs", {m_tdata_o[59:0], m_tvalid_o, buffer_read_v_o, clear_buffer_o, m_tlast_o}, 64'd0);
    check(packet_count_o == 16'd0 && drop_count_o == 16'd0, "midframe_reset_counters",
          64'({packet_count_o, drop_count_o}), 64'd0);
    exp_q.delete();
    exp_pkt = 1; exp_drop = 0;
    rd_cnt = 0; acc_cnt = 0; pending_clear = 0;
    push_frame(128);
    c0 = clear_seen;
    repeat (2) @(posedge clk);
    #1 reset_n_i = 1'b1;
    measure_latency();
    wait_clear(c0);
    finish_frame();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/eth_rx_stream_drainer.md
Name: eth_rx_stream_drainer

Overview:
- Downstream consumer of the MAC/buffer wrapper's receive side.
- When a received frame is ready, it reads the frame length, reads the receive buffer word by word, and presents the frame as an AXI-stream master with tkeep/tlast.
- After the last beat is accepted, it pulses clear_buffer so the buffer can take the next frame.
- It feeds the packet-processing logic in the same clock domain as the buffer.

Parameters:
- buf_size_p, 2048: receive buffer size in bytes.
- data_width_p, 64: buffer read width and stream width in bits; must be 32 or 64.
- addr_width_lp (local), $clog2(buf_size_p): byte address width.
- bytes_lp (local), data_width_p/8: bytes per word.

Ports:
- clk_i  in  1  logic clock (buffer domain).
- reset_n_i  in  1  asynchronous, active-low reset.
- rx_ready_i  in  1  buffer holds a complete frame.
- rx_packet_size_i  in  16  frame length in bytes; valid while rx_ready_i is high.
- clear_buffer_o  out  1  one-cycle pulse that releases the buffer.
- buffer_read_v_o  out  1  read request.
- buffer_read_addr_o  out  addr_width_lp  byte address, word aligned.
- buffer_read_op_size_o  out  2  fixed at log2(bytes_lp): 3 for 64-bit, 2 for 32-bit.
- buffer_read_data_i  in  data_width_p  read data, one cycle after the request.
- m_tdata_o  out  data_width_p  stream data.
- m_tkeep_o  out  bytes_lp  byte enables.
- m_tlast_o  out  1  last beat of the frame.
- m_tvalid_o  out  1  stream valid.
- m_tready_i  in  1  stream ready.
- packet_count_o  out  16  frames streamed; wraps.
- drop_count_o  out  16  frames dropped; wraps.

Behaviour:
- Reset (asynchronous assert, synchronous deassert handled outside the block): state IDLE; all outputs 0 except buffer_read_op_size_o, which is constant; FIFO empty; counters 0.
- Buffer read latency is fixed at 1 cycle: data for a request in cycle N is valid in N+1, unconditionally.
- FSM states: IDLE, READ, DRAIN, CLEAR, WAIT_NRDY.
- IDLE: when rx_ready_i=1, latch size, words = ceil(size/bytes_lp), rd_addr=0, beat counter=0.
  - If size==0 or size>buf_size_p: go to CLEAR and increment drop_count_o.
  - Otherwise: go to READ.
- READ: issue buffer_read_v_o=1 when (fifo_count + inflight) < 2.
  - Address = rd_addr; rd_addr advances by bytes_lp per issued read.
  - After the last word is issued, go to DRAIN.
- Output FIFO:
  - 2-entry FIFO, each entry {data, keep, last}. Its head drives m_* directly; there is no combinational path from m_tready_i to buffer_read_v_o.
  - A full FIFO with inflight=1 is impossible by the credit rule.
  - Simultaneous push and pop keeps the count unchanged.
- tkeep: all ones except on the last beat, where the low (size mod bytes_lp) bits are set; a remainder of 0 means all ones. tlast is set only on word index words-1.
- AXI rule: once m_tvalid_o is asserted, data/keep/last are held stable until m_tready_i=1.
- DRAIN: wait until the FIFO is empty and inflight=0, then go to CLEAR.
- CLEAR: clear_buffer_o=1 for exactly one cycle; if the frame was streamed, increment packet_count_o; go to WAIT_NRDY.
- WAIT_NRDY: stay until rx_ready_i=0, then go to IDLE. This prevents re-reading a stale frame.
- Latency: rx_ready_i sampled high in cycle N → first read issued in N+1 → first m_tvalid_o in N+3.
- Throughput: with m_tready_i held at 1, one beat per cycle.
- Size changes while not in IDLE are ignored; the latched value is used.
- Mid-frame reset: the FIFO is flushed and no clear pulse is issued; the buffer keeps its frame and is re-streamed from byte 0 after reset.

Decomposition:
- Package eth_rx_pkg: drainer state enum; fifo entry struct {data, keep, last}; function keep_for_bytes(rem) returning the tkeep mask.
- Sub-module eth_rx_skid_fifo: 2-entry valid/ready FIFO, parameterised by entry width; no other sub-modules.

Test Plan:
- 64-byte frame, m_tready_i=1 → 8 beats, keep=0xFF on every beat, tlast on beat 8, one clear_buffer_o pulse 1 cycle after beat 8 handshake; packet_count_o=1.
- 61-byte frame → 8 beats; last beat keep=0x1F; data matches buffer bytes 56..60.
- 64-byte frame with m_tready_i toggling 1/0 every cycle → data stable while stalled, no lost or duplicate beats, at most 2 reads outstanding plus queued.
- size=0, then size=2049 → no beats; one clear pulse each; drop_count_o=2.
- rx_ready_i held high after clear for 5 cycles → no second stream until rx_ready_i drops and rises again.
- reset_n_i asserted at beat 3 of a 128-byte frame → outputs 0 immediately; after release the full 16 beats are streamed from address 0.
